// File: rtl/hdmi_i2c_writer.sv
// hdmi_i2c_writer: one 3-byte I2C register write (slave addr+W, register, value) per request,
// reporting NACK back to the HDMI config sequencer.
module hdmi_i2c_writer #(
    parameter int CLK_HZ = 50_000_000,
    parameter int I2C_HZ = 20_000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [7:0]  addr,
    input  logic [15:0] data_in,
    input  logic        start,
    output logic        ready,
    output logic        error,
    output logic        i2c_scl,
    inout  wire         i2c_sda
);
    localparam int QDIV = CLK_HZ / (4 * I2C_HZ);
    localparam int CW = (QDIV < 2) ? 1 : $clog2(QDIV);

    if (QDIV < 2) begin : g_bad_qdiv
        $error("hdmi_i2c_writer: QDIV must be at least 2");
    end

    typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bitn_q, bitn_d;
    logic [1:0]    byte_q, byte_d;
    logic [23:0]   shift_q, shift_d;
    logic          error_q, error_d;
    logic          ready_q, ready_d;
    logic          scl_q, scl_d;
    logic          oe_q, oe_d;
    logic [1:0]    sync_q;
    logic          tick, accept;
    logic          unused_addr_msb;

    assign unused_addr_msb = addr[7];
    assign tick    = cnt_q == CW'(QDIV - 1);
    assign accept  = start && ready_q;
    assign ready   = ready_q;
    assign error   = error_q;
    assign i2c_scl = scl_q;
    assign i2c_sda = oe_q ? 1'b0 : 1'bz;

    always_comb begin
        state_d = state_q;
        cnt_d   = (tick || state_q == IDLE) ? '0 : cnt_q + 1'b1;
        qtr_d   = qtr_q;
        bitn_d  = bitn_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        error_d = error_q;
        if (accept) begin
            state_d = START;
            cnt_d   = '0;
            qtr_d   = '0;
            bitn_d  = '0;
            byte_d  = '0;
            shift_d = {addr[6:0], 1'b0, data_in};
            error_d = 1'b0;
        end else if (tick && state_q != IDLE) begin
            qtr_d = qtr_q + 1'b1;
            case (state_q)
                START: if (qtr_q == 2'd1) begin
                    state_d = BIT;
                    qtr_d   = '0;
                end
                BIT: if (qtr_q == 2'd3) begin
                    shift_d = shift_q << 1;
                    bitn_d  = bitn_q + 1'b1;
                    state_d = (bitn_q == 3'd7) ? ACK : BIT;
                end
                ACK: begin
                    if (qtr_q == 2'd2) error_d = sync_q[1];
                    if (qtr_q == 2'd3) begin
                        state_d = (error_q || byte_q == 2'd2) ? STOP : BIT;
                        byte_d  = byte_q + 1'b1;
                    end
                end
                STOP: if (qtr_q == 2'd3) state_d = IDLE;
                default: ;
            endcase
        end
        // outputs are decoded from the next state so the registered bus lines stay aligned to quarters
        ready_d = state_d == IDLE;
        scl_d   = 1'b1;
        oe_d    = 1'b0;
        case (state_d)
            START: begin
                scl_d = qtr_d == 2'd0;
                oe_d  = 1'b1;
            end
            BIT: begin
                scl_d = ^qtr_d;
                oe_d  = !shift_d[23];
            end
            ACK:  scl_d = ^qtr_d;
            STOP: begin
                scl_d = qtr_d != 2'd0;
                oe_d  = !qtr_d[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            qtr_q   <= '0;
            bitn_q  <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            error_q <= 1'b0;
            ready_q <= 1'b1;
            scl_q   <= 1'b1;
            oe_q    <= 1'b0;
            sync_q  <= 2'b11;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qtr_q   <= qtr_d;
            bitn_q  <= bitn_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            error_q <= error_d;
            ready_q <= ready_d;
            scl_q   <= scl_d;
            oe_q    <= oe_d;
            sync_q  <= {sync_q[0], i2c_sda};
        end
    end
endmodule
